// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / control-hazard stall and flush unit for the 5-stage pipeline
//
// Purpose:
//   Sits beside the ID stage. It raises load-use stalls (LOAD_LAT cycles) and
//   taken-branch flush windows (BR_FLUSH_CYC cycles). It also freezes the
//   pipeline while data memory is busy. One small FSM and one shared
//   down-counter track the multi-cycle windows. Outputs are combinational from
//   state, counter and inputs, so a stall asserts in the cycle it is detected.
//
// Optional build macro:
//   HAZ_PERF_CNT_EN - adds saturating 32-bit perf counters for load-stall and
//                     flush cycles (perf_ld_stall_cycles, perf_flush_cycles).
//
// Ports:
//   clk                  in   rising-edge clock
//   rst_n                in   asynchronous active-low reset
//   ex_mem_read          in   EX-stage instruction is a load
//   ex_rt                in   load destination register in EX
//   id_rs, id_rt         in   ID source registers
//   id_op                in   ID opcode
//   id_valid             in   ID holds a real instruction
//   ex_branch_taken      in   taken branch/jump resolved in EX
//   mem_busy             in   data memory not ready, freeze pipeline
//   pc_write_en          out  PC may update
//   ifid_write_en        out  IF/ID may update
//   ifid_flush           out  clear IF/ID to a bubble
//   idex_flush           out  load a bubble into ID/EX
//   stall_active         out  FSM is in LD_STALL or FLUSH
//   perf_ld_stall_cycles out  (HAZ_PERF_CNT_EN) load-stall cycle count
//   perf_flush_cycles    out  (HAZ_PERF_CNT_EN) IF/ID flush cycle count

module hazard_stall_ctrl #(
  parameter int              REG_AW       = 5,
  parameter int              OP_W         = 6,
  parameter int              LOAD_LAT     = 1,
  parameter int              BR_FLUSH_CYC = 1,
  parameter logic [OP_W-1:0] LW_OP        = 6'b100011,
  parameter logic [OP_W-1:0] XORI_OP      = 6'b001110
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [OP_W-1:0]   id_op,
  input  logic              id_valid,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              ifid_flush,
  output logic              idex_flush,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]       perf_ld_stall_cycles,
  output logic [31:0]       perf_flush_cycles,
`endif
  output logic              stall_active
);

  localparam int MAX_CYC = (LOAD_LAT > BR_FLUSH_CYC) ? LOAD_LAT : BR_FLUSH_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LD_RLD = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_BR_RLD = CNT_W'(BR_FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;

  logic hazard;
  logic state_legal;
  logic pc_we_c;
  logic ifid_we_c;
  logic ifid_fl_c;
  logic idex_fl_c;

  // lw and xori take rt as a destination, so a match on rt is not a real use.
  // Register 0 is hard-wired and never creates a dependency.
  assign hazard = id_valid & ex_mem_read & (ex_rt != '0) &
                  ((ex_rt == id_rs) |
                   ((ex_rt == id_rt) & (id_op != LW_OP) & (id_op != XORI_OP)));

  assign state_legal = (state == ST_RUN) || (state == ST_LD_STALL) || (state == ST_FLUSH);

  // Next-state and raw control decode. Priority: mem_busy, branch, load hazard.
  always_comb begin
    pc_we_c   = 1'b1;
    ifid_we_c = 1'b1;
    ifid_fl_c = 1'b0;
    idex_fl_c = 1'b0;
    nxt_state = state;
    nxt_cnt   = cnt;

    if (mem_busy) begin
      // Full freeze: nothing advances, nothing is squashed, window is paused.
      pc_we_c   = 1'b0;
      ifid_we_c = 1'b0;
      if (!state_legal) begin
        nxt_state = ST_RUN;
        nxt_cnt   = '0;
      end
    end else if (ex_branch_taken) begin
      // Taken branch in EX is older than anything in ID: it overrides a
      // pending load stall (squashing the held ID instruction) and restarts
      // an ongoing flush window.
      ifid_fl_c = 1'b1;
      idex_fl_c = 1'b1;
      if (BR_FLUSH_CYC > 1) begin
        nxt_state = ST_FLUSH;
        nxt_cnt   = CNT_BR_RLD;
      end else begin
        nxt_state = ST_RUN;
        nxt_cnt   = '0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard) begin
            pc_we_c   = 1'b0;
            ifid_we_c = 1'b0;
            idex_fl_c = 1'b1;
            if (LOAD_LAT > 1) begin
              nxt_state = ST_LD_STALL;
              nxt_cnt   = CNT_LD_RLD;
            end
          end
        end

        ST_LD_STALL: begin
          // EX holds a bubble here, so a fresh ex_mem_read is not examined.
          pc_we_c   = 1'b0;
          ifid_we_c = 1'b0;
          idex_fl_c = 1'b1;
          if (cnt <= CNT_ONE) begin
            nxt_state = ST_RUN;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt - CNT_ONE;
          end
        end

        ST_FLUSH: begin
          // Wrong-path fetches keep flowing but are squashed; H is irrelevant.
          ifid_fl_c = 1'b1;
          idex_fl_c = 1'b1;
          if (cnt <= CNT_ONE) begin
            nxt_state = ST_RUN;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt - CNT_ONE;
          end
        end

        default: begin
          nxt_state = ST_RUN;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // While reset is low the pipeline is held with both bubble controls set,
  // independent of whatever the inputs are doing.
  assign pc_write_en   = rst_n & pc_we_c;
  assign ifid_write_en = rst_n & ifid_we_c;
  assign ifid_flush    = ~rst_n | ifid_fl_c;
  assign idex_flush    = ~rst_n | idex_fl_c;
  assign stall_active  = rst_n & ((state == ST_LD_STALL) | (state == ST_FLUSH));

`ifdef HAZ_PERF_CNT_EN
  logic ld_stall_cyc;

  // Cycles where the PC is held because of a load, not because of memory.
  assign ld_stall_cyc = ~mem_busy & ~ex_branch_taken &
                        (((state == ST_RUN) & hazard) | (state == ST_LD_STALL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ld_stall_cycles <= '0;
      perf_flush_cycles    <= '0;
    end else begin
      if (ld_stall_cyc && (perf_ld_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_ld_stall_cycles <= perf_ld_stall_cycles + 32'd1;
      end
      if (ifid_flush && (perf_flush_cycles != 32'hFFFF_FFFF)) begin
        perf_flush_cycles <= perf_flush_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised load-use and control-hazard unit for the 5-stage pipeline.
- Generalises the single-cycle load-use stall in three ways:
  - multi-cycle load latency (LOAD_LAT stall cycles);
  - multi-cycle taken-branch flush window;
  - memory-busy pipeline freeze.
- Sits beside the ID stage. Drives PC/IF-ID write enables and the IF/ID and ID/EX bubble controls. Holds a small FSM and a shared down-counter.

Parameters:
- REG_AW, 5, register-address width.
- OP_W, 6, opcode width.
- LOAD_LAT, 1, load-use stall cycles (>=1).
- BR_FLUSH_CYC, 1, flush cycles after a taken branch (>=1).
- LW_OP, 6'b100011, load opcode (ID does not read rt).
- XORI_OP, 6'b001110, xori opcode (ID does not read rt).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_mem_read  in  1  EX-stage instruction is a load.
- ex_rt  in  REG_AW  load destination in EX.
- id_rs  in  REG_AW  ID source register rs.
- id_rt  in  REG_AW  ID source register rt.
- id_op  in  OP_W  ID opcode.
- id_valid  in  1  ID holds a real instruction.
- ex_branch_taken  in  1  taken branch/jump resolved in EX.
- mem_busy  in  1  data memory not ready; freeze pipeline.
- pc_write_en  out  1  PC may update.
- ifid_write_en  out  1  IF/ID may update.
- ifid_flush  out  1  clear IF/ID to bubble.
- idex_flush  out  1  load bubble into ID/EX.
- stall_active  out  1  FSM in LD_STALL or FLUSH.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, cnt=0.
  - Outputs forced: pc_write_en=0, ifid_write_en=0, ifid_flush=1, idex_flush=1, stall_active=0.
- Hazard condition H:
  - H = id_valid & ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | ((ex_rt==id_rt) & id_op!=LW_OP & id_op!=XORI_OP)).
  - Register 0 never hazards.
- Outputs are combinational from state, cnt and inputs. Zero-latency: a stall asserts in the detection cycle.
- cnt width is clog2(max(LOAD_LAT,BR_FLUSH_CYC)+1).
- Priority, highest first: mem_busy, ex_branch_taken, H.
- mem_busy=1, any state:
  - pc_write_en=0, ifid_write_en=0, ifid_flush=0, idex_flush=0.
  - state and cnt hold. stall_active reflects the held state.
- RUN, ex_branch_taken=1:
  - pc_write_en=1, ifid_write_en=1, ifid_flush=1, idex_flush=1.
  - If BR_FLUSH_CYC>1: next state FLUSH, cnt=BR_FLUSH_CYC-1. Otherwise stay RUN.
- RUN, H=1:
  - pc_write_en=0, ifid_write_en=0, idex_flush=1, ifid_flush=0.
  - If LOAD_LAT>1: next state LD_STALL, cnt=LOAD_LAT-1.
- RUN, otherwise: write enables=1, flushes=0.
- LD_STALL:
  - pc_write_en=0, ifid_write_en=0, idex_flush=1, ifid_flush=0.
  - cnt decrements each cycle; at cnt==1 next state is RUN.
  - Total stall cycles = LOAD_LAT.
  - A new ex_mem_read is ignored (EX holds a bubble).
- LD_STALL, ex_branch_taken=1 (older branch in EX): abort the stall and handle exactly as RUN+branch. The held ID instruction is squashed.
- FLUSH:
  - pc_write_en=1, ifid_write_en=1, ifid_flush=1, idex_flush=1. H is ignored.
  - cnt decrements; at cnt==1 next state is RUN.
  - ex_branch_taken in FLUSH reloads cnt=BR_FLUSH_CYC-1.
- Reset mid-stall or mid-flush: immediately returns to RUN with cnt=0 and no residual stall after release.
- Illegal state encodings recover to RUN next cycle.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs perf_ld_stall_cycles [31:0] and perf_flush_cycles [31:0].
  - perf_ld_stall_cycles counts cycles with pc_write_en=0 caused by H or LD_STALL. mem_busy cycles are excluded.
  - perf_flush_cycles counts cycles with ifid_flush=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- LOAD_LAT=1: ex_mem_read=1, ex_rt=5, id_rs=5, id_valid=1 -> one cycle of pc_write_en=0, ifid_write_en=0, idex_flush=1; RUN next cycle.
- LOAD_LAT=3: ex_rt=7, id_rt=7, id_op=6'b000000 -> exactly 3 stall cycles, stall_active=1 on cycles 2-3; same stimulus with id_op=LW_OP or ex_rt=0 -> no stall.
- LOAD_LAT=3: hazard, then ex_branch_taken=1 in the second stall cycle -> ifid_flush=1, idex_flush=1, pc_write_en=1 that cycle; state RUN after (BR_FLUSH_CYC=1).
- BR_FLUSH_CYC=3: branch with simultaneous H -> branch wins; 3 consecutive flush cycles, no load stall.
- mem_busy=1 for 2 cycles in the middle of LD_STALL (LOAD_LAT=3) -> all enables/flushes 0 for those cycles; total LOAD_LAT stall cycles still 3 afterward.
- rst_n pulled low mid-FLUSH -> outputs at reset values immediately; after release, first idle cycle has pc_write_en=1, stall_active=0; with HAZ_PERF_CNT_EN both counters read 0.
